os_generator: RTL and testbench



---
 rtl/pcie_os_pkg.sv | 45 ++++
 rtl/os_symbol_lane.sv | 85 ++++++++
 rtl/os_generator.sv | 130 +++++++++++++
 tb/tb_os_generator.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_os_pkg.sv
// Shared ordered-set codes, symbol constants, lengths and FSM encoding.
package pcie_os_pkg;

  localparam int unsigned SYM_W   = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TS_LEN  = 16;
  localparam int unsigned SHORT_LEN = 4;

  // OSType codes, also used by the LTSSM
  localparam logic [2:0] OS_TS1  = 3'b000;
  localparam logic [2:0] OS_TS2  = 3'b001;
  localparam logic [2:0] OS_EIOS = 3'b010;
  localparam logic [2:0] OS_SKP  = 3'b011;
  localparam logic [2:0] OS_IDLE = 3'b100;

  // LaneNumber modes; the remaining codes mean PAD
  localparam logic [1:0] LANE_SEQ = 2'b01;
  localparam logic [1:0] LANE_REV = 2'b10;

  // Symbol constants
  localparam logic [SYM_W-1:0] COM    = 8'hBC;
  localparam logic [SYM_W-1:0] PAD    = 8'hF7;
  localparam logic [SYM_W-1:0] IDL    = 8'h7C;
  localparam logic [SYM_W-1:0] SKP    = 8'h1C;
  localparam logic [SYM_W-1:0] TS1_ID = 8'h4A;
  localparam logic [SYM_W-1:0] TS2_ID = 8'h45;

  typedef enum logic [1:0] {
    IDLE_ST = 2'd0,
    SEND_ST = 2'd1,
    DONE_ST = 2'd2
  } osState_t;

  // Codes above IDLE are reserved
  function automatic logic isValidType(input logic [2:0] osType);
    return osType <= OS_IDLE;
  endfunction

  // Index of the final symbol of an ordered set
  function automatic logic [CNT_W-1:0] lastSymbol(input logic [2:0] osType);
    if (osType == OS_EIOS || osType == OS_SKP) return CNT_W'(SHORT_LEN - 1);
    return CNT_W'(TS_LEN - 1);
  endfunction

endpackage

// File: rtl/os_symbol_lane.sv
// Per-lane ordered-set symbol lookup: fields + lane index + symbol index -> {K, symbol}.
module os_symbol_lane
  import pcie_os_pkg::*;
#(
  parameter int unsigned LANESNUMBER = 16,
  parameter logic [7:0]  NFTS        = 8'd255
) (
  input  logic [2:0]       osType,
  input  logic [7:0]       linkNumber,
  input  logic [1:0]       laneMode,
  input  logic [2:0]       rate,
  input  logic             loopback,
  input  logic [4:0]       laneIndex,
  input  logic [CNT_W-1:0] symIdx,
  output logic             symK_c,
  output logic [SYM_W-1:0] symbol_c
);

  logic [4:0]       laneNum;
  logic             lanePad;
  logic [SYM_W-1:0] rateId;
  logic [SYM_W-1:0] tsId;

  // Lane number, rate identifier and TS identifier derived from the fields
  always_comb begin
    laneNum = 5'd0;
    lanePad = 1'b1;
    if (laneMode == LANE_SEQ) begin
      laneNum = laneIndex;
      lanePad = 1'b0;
    end else if (laneMode == LANE_REV) begin
      laneNum = 5'(LANESNUMBER - 1) - laneIndex;
      lanePad = 1'b0;
    end
    case (rate)
      3'd0, 3'd1: rateId = 8'h02;
      3'd2:       rateId = 8'h06;
      3'd3:       rateId = 8'h0E;
      3'd4:       rateId = 8'h1E;
      default:    rateId = 8'h3E;
    endcase
    tsId = (osType == OS_TS1) ? TS1_ID : TS2_ID;
  end

  // Symbol selection by ordered-set type and position
  always_comb begin
    symK_c   = 1'b0;
    symbol_c = '0;
    case (osType)
      OS_TS1, OS_TS2: begin
        case (symIdx)
          4'd0: begin
            symK_c   = 1'b1;
            symbol_c = COM;
          end
          4'd1: begin
            symK_c   = (linkNumber == 8'h00);
            symbol_c = (linkNumber == 8'h00) ? PAD : linkNumber;
          end
          4'd2: begin
            symK_c   = lanePad;
            symbol_c = lanePad ? PAD : {3'b000, laneNum};
          end
          4'd3:    symbol_c = NFTS;
          4'd4:    symbol_c = rateId;
          4'd5:    symbol_c = {5'b00000, loopback, 2'b00};
          default: symbol_c = tsId;
        endcase
      end
      OS_EIOS: begin
        symK_c   = 1'b1;
        symbol_c = (symIdx == '0) ? COM : IDL;
      end
      OS_SKP: begin
        symK_c   = 1'b1;
        symbol_c = (symIdx == '0) ? COM : SKP;
      end
      default: begin
        symK_c   = 1'b0;
        symbol_c = '0;
      end
    endcase
  end

endmodule

// File: rtl/os_generator.sv
// Ordered-set generator: latches LTSSM fields on Start and emits one OS, one symbol per lane per Pclk.
module os_generator
  import pcie_os_pkg::*;
#(
  parameter int unsigned LANESNUMBER = 16,
  parameter int unsigned PIPEWIDTH   = 8,
  parameter logic [7:0]  NFTS        = 8'd255
) (
  input  logic                             Pclk,
  input  logic                             Reset,
  input  logic [2:0]                       OSType,
  input  logic [1:0]                       LaneNumber,
  input  logic [7:0]                       LinkNumber,
  input  logic [2:0]                       Rate,
  input  logic                             Loopback,
  input  logic                             OSGeneratorStart,
  output logic                             OSGeneratorBusy,
  output logic                             OSGeneratorFinish,
  output logic [PIPEWIDTH*LANESNUMBER-1:0] TxData,
  output logic [LANESNUMBER-1:0]           TxDataK,
  output logic                             TxDataValid
);

  osState_t         state, nextState;
  logic [CNT_W-1:0] count, nextCount;
  logic [2:0]       osTypeQ, selType;
  logic [7:0]       linkQ, selLink;
  logic [1:0]       laneModeQ, selLaneMode;
  logic [2:0]       rateQ, selRate;
  logic             loopbackQ, selLoopback;
  logic             accept, emit, nextBusy, nextValid, nextFinish;

  logic [PIPEWIDTH*LANESNUMBER-1:0] laneData;
  logic [LANESNUMBER-1:0]           laneK;

  // Next state, next symbol index and next output flags
  always_comb begin
    nextState  = state;
    nextCount  = count;
    accept     = 1'b0;
    emit       = 1'b0;
    nextBusy   = 1'b0;
    nextValid  = 1'b0;
    nextFinish = 1'b0;
    case (state)
      SEND_ST: begin
        if (count == lastSymbol(osTypeQ)) begin
          nextState  = DONE_ST;
          nextFinish = 1'b1;
        end else begin
          nextCount = count + 1'b1;
          emit      = 1'b1;
          nextBusy  = 1'b1;
          nextValid = 1'b1;
        end
      end
      default: begin
        // IDLE_ST and DONE_ST both accept a new request
        if (OSGeneratorStart && isValidType(OSType)) begin
          accept    = 1'b1;
          nextState = SEND_ST;
          nextCount = '0;
          emit      = 1'b1;
          nextBusy  = 1'b1;
          nextValid = 1'b1;
        end else begin
          nextState = IDLE_ST;
        end
      end
    endcase
    // Symbol 0 is built from the live inputs, later symbols from the latched copy
    selType     = accept ? OSType     : osTypeQ;
    selLink     = accept ? LinkNumber : linkQ;
    selLaneMode = accept ? LaneNumber : laneModeQ;
    selRate     = accept ? Rate       : rateQ;
    selLoopback = accept ? Loopback   : loopbackQ;
  end

  // One symbol lookup per lane
  for (genvar i = 0; i < LANESNUMBER; i++) begin : gLane
    os_symbol_lane #(
      .LANESNUMBER(LANESNUMBER),
      .NFTS       (NFTS)
    ) uLane (
      .osType    (selType),
      .linkNumber(selLink),
      .laneMode  (selLaneMode),
      .rate      (selRate),
      .loopback  (selLoopback),
      .laneIndex (5'(i)),
      .symIdx    (nextCount),
      .symK_c    (laneK[i]),
      .symbol_c  (laneData[PIPEWIDTH*i +: PIPEWIDTH])
    );
  end

  // State, counter, latched fields and registered outputs
  always_ff @(posedge Pclk or posedge Reset) begin
    if (Reset) begin
      state             <= IDLE_ST;
      count             <= '0;
      osTypeQ           <= '0;
      linkQ             <= '0;
      laneModeQ         <= '0;
      rateQ             <= '0;
      loopbackQ         <= 1'b0;
      OSGeneratorBusy   <= 1'b0;
      OSGeneratorFinish <= 1'b0;
      TxDataValid       <= 1'b0;
      TxData            <= '0;
      TxDataK           <= '0;
    end else begin
      state             <= nextState;
      count             <= nextCount;
      if (accept) begin
        osTypeQ   <= OSType;
        linkQ     <= LinkNumber;
        laneModeQ <= LaneNumber;
        rateQ     <= Rate;
        loopbackQ <= Loopback;
      end
      OSGeneratorBusy   <= nextBusy;
      OSGeneratorFinish <= nextFinish;
      TxDataValid       <= nextValid;
      TxData            <= emit ? laneData : '0;
      TxDataK           <= emit ? laneK : '0;
    end
  end

endmodule

// File: tb/tb_os_generator.sv
// Self-checking bench for os_generator: directed vector table, hand sequences, random OSes vs reference model.
module tb_os_generator;

  localparam int unsigned LANES = 16;
  localparam int unsigned DW    = 8 * LANES;

  typedef struct packed {
    logic [2:0] osType;
    logic [7:0] link;
    logic [1:0] laneMode;
    logic [2:0] rate;
    logic       loopback;
  } osReq_t;

  typedef struct packed {
    osReq_t          req;
    logic [4:0]      lane;
    logic [15:0][7:0] syms;
    logic [15:0]     kMask;
  } vec_t;

  logic            Pclk = 1'b0;
  logic            Reset;
  logic [2:0]      OSType;
  logic [1:0]      LaneNumber;
  logic [7:0]      LinkNumber;
  logic [2:0]      Rate;
  logic            Loopback;
  logic            OSGeneratorStart;
  logic            OSGeneratorBusy;
  logic            OSGeneratorFinish;
  logic [DW-1:0]   TxData;
  logic [LANES-1:0] TxDataK;
  logic            TxDataValid;

  int checkCount = 0;
  int passCount  = 0;
  logic [DW-1:0]    capData [16];
  logic [LANES-1:0] capK    [16];
  time finishTime = 0;

  os_generator #(
    .LANESNUMBER(LANES),
    .PIPEWIDTH  (8),
    .NFTS       (8'd255)
  ) dut (
    .Pclk             (Pclk),
    .Reset            (Reset),
    .OSType           (OSType),
    .LaneNumber       (LaneNumber),
    .LinkNumber       (LinkNumber),
    .Rate             (Rate),
    .Loopback         (Loopback),
    .OSGeneratorStart (OSGeneratorStart),
    .OSGeneratorBusy  (OSGeneratorBusy),
    .OSGeneratorFinish(OSGeneratorFinish),
    .TxData           (TxData),
    .TxDataK          (TxDataK),
    .TxDataValid      (TxDataValid)
  );

  always #5 Pclk = ~Pclk;

  initial begin
    #400000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: the symbol a lane carries at position k of the requested OS
  function automatic logic [8:0] refLane(input osReq_t r, input int lane, input int k);
    int rr;
    if (r.osType == 3'd2) return (k == 0) ? {1'b1, 8'hBC} : {1'b1, 8'h7C};
    if (r.osType == 3'd3) return (k == 0) ? {1'b1, 8'hBC} : {1'b1, 8'h1C};
    if (r.osType == 3'd4) return 9'h000;
    rr = (r.rate == 0) ? 1 : ((r.rate > 5) ? 5 : int'(r.rate));
    if (k == 0) return {1'b1, 8'hBC};
    if (k == 1) return (r.link == 8'h00) ? {1'b1, 8'hF7} : {1'b0, r.link};
    if (k == 2) begin
      if (r.laneMode == 2'b01) return {1'b0, 8'(lane)};
      if (r.laneMode == 2'b10) return {1'b0, 8'(int'(LANES) - 1 - lane)};
      return {1'b1, 8'hF7};
    end
    if (k == 3) return {1'b0, 8'hFF};
    if (k == 4) return {1'b0, 8'(((1 << (rr + 1)) - 1) & ~1)};
    if (k == 5) return {1'b0, 8'(r.loopback ? 4 : 0)};
    return {1'b0, (r.osType == 3'd0) ? 8'h4A : 8'h45};
  endfunction

  function automatic int osLen(input logic [2:0] t);
    return (t == 3'd2 || t == 3'd3) ? 4 : 16;
  endfunction

  function automatic logic [15:0][7:0] tsSyms(input logic [7:0] s1, s2, s4, s5, id);
    logic [15:0][7:0] s;
    for (int i = 0; i < 16; i++) s[i] = id;
    s[0] = 8'hBC; s[1] = s1; s[2] = s2; s[3] = 8'hFF; s[4] = s4; s[5] = s5;
    return s;
  endfunction

  // Drives one request at the current negedge, checks every symbol and the Finish cycle.
  // Returns at the Finish negedge with Start low, so a caller may chain a Start into it.
  task automatic runOs(input osReq_t r, input bit noise, input string tag);
    int len;
    logic [DW-1:0]    expData;
    logic [LANES-1:0] expK;
    logic [8:0]       ls;
    len = osLen(r.osType);
    OSType = r.osType; LinkNumber = r.link; LaneNumber = r.laneMode;
    Rate = r.rate; Loopback = r.loopback; OSGeneratorStart = 1'b1;
    for (int k = 0; k < len; k++) begin
      @(negedge Pclk);
      expData = '0;
      expK    = '0;
      for (int i = 0; i < int'(LANES); i++) begin
        ls = refLane(r, i, k);
        expData[8*i +: 8] = ls[7:0];
        expK[i] = ls[8];
      end
      capData[k] = TxData;
      capK[k]    = TxDataK;
      check({tag, " data"}, TxData, expData);
      check({tag, " k"}, DW'(TxDataK), DW'(expK));
      check({tag, " busy/valid/finish"},
            DW'({OSGeneratorBusy, TxDataValid, OSGeneratorFinish}), DW'(3'b110));
      if (noise) begin
        OSType = 3'($urandom_range(0, 7)); LinkNumber = 8'($urandom);
        LaneNumber = 2'($urandom); Rate = 3'($urandom); Loopback = 1'($urandom);
        OSGeneratorStart = 1'b1;
      end else begin
        OSGeneratorStart = 1'b0;
      end
    end
    OSGeneratorStart = 1'b0;
    @(negedge Pclk);
    check({tag, " finish flags"},
          DW'({OSGeneratorBusy, TxDataValid, OSGeneratorFinish}), DW'(3'b001));
    check({tag, " finish data"}, TxData | DW'(TxDataK), '0);
    finishTime = $time;
  endtask

  task automatic checkIdle(input string tag);
    check({tag, " idle flags"},
          DW'({OSGeneratorBusy, TxDataValid, OSGeneratorFinish}), DW'(3'b000));
    check({tag, " idle data"}, TxData | DW'(TxDataK), '0);
  endtask

  vec_t vecs [6];
  osReq_t r;
  time t1;

  initial begin
    Reset = 1'b1; OSType = '0; LaneNumber = '0; LinkNumber = '0;
    Rate = '0; Loopback = 1'b0; OSGeneratorStart = 1'b0;
    #1;
    checkIdle("reset");
    @(negedge Pclk); @(negedge Pclk);
    Reset = 1'b0;
    @(negedge Pclk);
    checkIdle("post reset");

    // Directed vectors: one lane of each OS against hand-derived constants
    vecs[0] = '{req: '{3'd0, 8'h01, 2'b01, 3'd3, 1'b0}, lane: 5'd2,
                syms: tsSyms(8'h01, 8'h02, 8'h0E, 8'h00, 8'h4A), kMask: 16'h0001};
    vecs[1] = '{req: '{3'd1, 8'h00, 2'b00, 3'd2, 1'b1}, lane: 5'd5,
                syms: tsSyms(8'hF7, 8'hF7, 8'h06, 8'h04, 8'h45), kMask: 16'h0007};
    vecs[2] = '{req: '{3'd0, 8'h20, 2'b10, 3'd0, 1'b0}, lane: 5'd0,
                syms: tsSyms(8'h20, 8'h0F, 8'h02, 8'h00, 8'h4A), kMask: 16'h0001};
    vecs[3] = '{req: '{3'd0, 8'h20, 2'b10, 3'd7, 1'b0}, lane: 5'd15,
                syms: tsSyms(8'h20, 8'h00, 8'h3E, 8'h00, 8'h4A), kMask: 16'h0001};
    vecs[4] = '{req: '{3'd4, 8'h33, 2'b01, 3'd3, 1'b1}, lane: 5'd9,
                syms: '0, kMask: 16'h0000};
    vecs[5] = '{req: '{3'd1, 8'h55, 2'b11, 3'd5, 1'b0}, lane: 5'd3,
                syms: tsSyms(8'h55, 8'hF7, 8'h3E, 8'h00, 8'h45), kMask: 16'h0005};
    for (int v = 0; v < 6; v++) begin
      runOs(vecs[v].req, 1'b0, $sformatf("vec%0d", v));
      for (int k = 0; k < 16; k++) begin
        check($sformatf("vec%0d lane%0d sym%0d", v, vecs[v].lane, k),
              DW'(capData[k][8*vecs[v].lane +: 8]), DW'(vecs[v].syms[k]));
        check($sformatf("vec%0d lane%0d k%0d", v, vecs[v].lane, k),
              DW'(capK[k][vecs[v].lane]), DW'(vecs[v].kMask[k]));
      end
      @(negedge Pclk);
      checkIdle($sformatf("vec%0d", v));
    end

    // Reset in the middle of a TS1 (symbol 7 on the bus)
    OSType = 3'd0; LinkNumber = 8'h01; LaneNumber = 2'b01; Rate = 3'd3;
    Loopback = 1'b0; OSGeneratorStart = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge Pclk);
      OSGeneratorStart = 1'b0;
    end
    check("mid ts1 sym7 lane0", DW'({TxDataValid, TxData[7:0]}), DW'({1'b1, 8'h4A}));
    #2 Reset = 1'b1;
    #1 checkIdle("async reset");
    @(negedge Pclk);
    checkIdle("held reset");
    Reset = 1'b0;
    @(negedge Pclk);
    checkIdle("after reset");
    r = '{3'd0, 8'h01, 2'b01, 3'd3, 1'b0};
    runOs(r, 1'b0, "ts1 after reset");
    @(negedge Pclk);

    // EIOS, then SKP requested in the Finish cycle
    r = '{3'd2, 8'h00, 2'b00, 3'd1, 1'b0};
    runOs(r, 1'b0, "eios");
    check("eios lane0 syms",
          DW'({capData[0][7:0], capData[1][7:0], capData[2][7:0], capData[3][7:0]}),
          DW'(32'hBC7C7C7C));
    check("eios lane0 k", DW'({capK[0][0], capK[1][0], capK[2][0], capK[3][0]}), DW'(4'hF));
    t1 = finishTime;
    r = '{3'd3, 8'h00, 2'b00, 3'd1, 1'b0};
    runOs(r, 1'b0, "skp chained");
    check("skp lane3 syms",
          DW'({capData[0][31:24], capData[1][31:24], capData[2][31:24], capData[3][31:24]}),
          DW'(32'hBC1C1C1C));
    check("finish spacing", DW'(finishTime - t1), DW'(50));
    @(negedge Pclk);
    checkIdle("after skp");

    // IDLE OS with Start re-pulsed while busy, then a reserved type
    r = '{3'd4, 8'h12, 2'b01, 3'd2, 1'b0};
    runOs(r, 1'b1, "idle os noisy");
    OSType = 3'b110; OSGeneratorStart = 1'b1;
    @(negedge Pclk);
    OSGeneratorStart = 1'b0;
    checkIdle("reserved c1");
    @(negedge Pclk);
    checkIdle("reserved c2");
    @(negedge Pclk);
    checkIdle("reserved c3");

    // Random requests against the reference model
    for (int n = 0; n < 30; n++) begin
      r.osType   = 3'($urandom_range(0, 4));
      r.link     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      r.laneMode = 2'($urandom);
      r.rate     = 3'($urandom);
      r.loopback = 1'($urandom);
      runOs(r, 1'b1, $sformatf("rand%0d", n));
      if ($urandom_range(0, 2) != 0) begin
        @(negedge Pclk);
        checkIdle($sformatf("rand%0d gap", n));
        if ($urandom_range(0, 1) == 1) begin
          OSType = 3'($urandom_range(5, 7)); OSGeneratorStart = 1'b1;
          @(negedge Pclk);
          OSGeneratorStart = 1'b0;
          checkIdle($sformatf("rand%0d reserved", n));
        end
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
